progmem_arbiter: RTL and testbench
==================================

Name: progmem_arbiter

Overview:
- Two-master round-robin arbiter in front of the single-port on-chip program/data RAM: 32-bit words, 15-bit word address, 28912 words.
- Master 0 is the Nios data master; master 1 is the DMA/loader port.
- Issues at most one access per cycle to the RAM.
- Tracks the RAM's 1-cycle read latency, routes read data back to the issuing master, and blocks out-of-range accesses.

Parameters:
- ADDR_W, 15, word-address width.
- DATA_W, 32, data width; BE_W = DATA_W/8.
- DEPTH, 28912, number of valid words; addresses >= DEPTH are out of range.
- MAX_LOCK, 8, maximum consecutive locked grants to one master while the other is requesting (1..255).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- mi_read / mi_write  in  1 each  per-master request (i = 0, 1)
- mi_address  in  ADDR_W  word address
- mi_byteenable  in  BE_W  byte lanes
- mi_writedata  in  DATA_W  write data
- mi_lock  in  1  keep the grant while asserted
- mi_waitrequest  out  1  request not accepted this cycle
- mi_readdata  out  DATA_W  read data
- mi_readdatavalid  out  1  read data valid
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  BE_W  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_readdata  in  DATA_W  from RAM; valid the cycle after the address
- freeze  in  1  stop issuing new grants
- range_err  out  1  sticky out-of-range flag
- range_err_clr  in  1  clears range_err

Behaviour:
- Request: req_i = mi_read | mi_write. If both are high, the access is a write and the read is ignored.
- Grant is combinational each cycle; accept_i = req_i & ~mi_waitrequest.
- mi_waitrequest = req_i & ~gnt_i.
- gnt is forced to 0 when freeze = 1 or when reset_n = 0.
- Priority pointer `last` (register) records the last master granted. When both request, the master != last wins.
- Lock: if the previous grant was to master k with mk_lock = 1, mk is still requesting and lock_cnt < MAX_LOCK, then k wins.
  - lock_cnt increments on each consecutive locked grant to the same master while the other is requesting.
  - lock_cnt resets to 0 on a grant to the other master or when the lock drops.
  - lock_cnt saturates; at MAX_LOCK the other master gets exactly one grant.
- RAM drive: mem_address, mem_byteenable and mem_writedata come from the granted master.
  - mem_chipselect = any grant & in_range.
  - mem_write = granted write & in_range.
  - Outputs are combinational (RAM registers its address).
  - With no grant, mem_chipselect = mem_write = 0.
- Read pipeline: on an accepted read, next cycle rd_pend = 1, rd_id = granted master, rd_oor = ~in_range.
  - mi_readdatavalid = rd_pend & (rd_id == i).
  - mi_readdata = rd_oor ? 0 : mem_readdata, broadcast to both masters.
  - Back-to-back reads from either master are supported at 1 read per cycle, latency exactly 1 cycle after acceptance.
- Out of range (address >= DEPTH):
  - The access is still accepted (no hang).
  - A write is dropped.
  - A read returns 0 with readdatavalid.
  - range_err is set on the cycle after acceptance.
  - range_err_clr clears it; a set in the same cycle as a clear wins.
- freeze: an in-flight read still completes (rd_pend drains); no new accepts.
- Reset (async, any time): last = 1 (master 0 wins first), lock_cnt = 0, rd_pend = 0, rd_id = 0, rd_oor = 0, range_err = 0.
  - All readdatavalid = 0, mem_chipselect = 0, mem_write = 0, waitrequest = req.
  - A read in flight at reset is discarded; no valid appears after reset release.

Test Plan:
- After reset, m0 and m1 both read at addresses 0x0010 / 0x0020 for 4 cycles -> grants alternate m0, m1, m0, m1. Each readdatavalid arrives 1 cycle after its accept, to the correct master, with preloaded data.
- m0 writes 0xDEADBEEF with be = 4'b0011 to 0x0100, then reads it -> read returns 0x????BEEF with the upper bytes preserved. mem_write pulses for exactly 1 cycle.
- m0_lock = 1 with both masters requesting continuously, MAX_LOCK = 8 -> m0 granted 8 consecutive cycles (1 normal + locked), then m1 granted once, then m0 resumes.
- m1 writes to address 28912 -> mem_chipselect = 0, waitrequest = 0, range_err = 1 next cycle. A subsequent read of 28912 returns 0 with valid. range_err_clr drops range_err.
- Read accepted, freeze asserted the next cycle -> readdatavalid still delivered. All later requests see waitrequest = 1 until freeze deasserts.
- Read accepted, reset_n pulsed low mid-cycle before data returns -> no readdatavalid after release. First grant after reset goes to m0.

Source files
------------

// File: rtl/progmem_arbiter_if.sv
// Per-master bus to the program/data RAM arbiter.
// The master drives the request fields; the arbiter returns handshake and read data.
interface progmem_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W/8-1:0]   byteenable;
    logic [DATA_W-1:0]     writedata;
    logic                  lock;
    logic                  waitrequest;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;

    modport master (
        output read, write, address, byteenable, writedata, lock,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  read, write, address, byteenable, writedata, lock,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/progmem_arbiter.sv
// Two-master round-robin arbiter with lock support in front of a single-port RAM
// with 1-cycle read latency; out-of-range accesses are absorbed and flagged.
module progmem_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 28912,
    parameter int MAX_LOCK = 8,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic               clk,
    input  logic               reset_n,
    progmem_arbiter_if.slave   m0,
    progmem_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BE_W-1:0]    mem_byteenable,
    output logic [DATA_W-1:0]  mem_writedata,
    output logic               mem_chipselect,
    output logic               mem_write,
    input  logic [DATA_W-1:0]  mem_readdata,
    input  logic               freeze,
    output logic               range_err,
    input  logic               range_err_clr
);

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    localparam logic [7:0]      LOCK_LIMIT  = 8'(MAX_LOCK);
    localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W + 1)'(DEPTH);

    master_e    last;
    master_e    last_next;
    logic [7:0] lock_cnt;
    logic [7:0] lock_cnt_next;

    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic accept;
    logic last_lock;
    logic lock_hold;
    logic gnt_lock;
    logic other_req;
    logic sel_write;
    logic in_range;

    logic rd_pend;
    logic rd_id;
    logic rd_oor;

    assign req0      = m0.read | m0.write;
    assign req1      = m1.read | m1.write;
    assign last_lock = (last == M0) ? m0.lock : m1.lock;
    assign lock_hold = last_lock & (lock_cnt < LOCK_LIMIT);
    assign accept    = gnt0 | gnt1;
    assign gnt_lock  = gnt1 ? m1.lock : m0.lock;
    assign other_req = gnt1 ? req0 : req1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last     <= M1;
            lock_cnt <= '0;
        end else begin
            last     <= last_next;
            lock_cnt <= lock_cnt_next;
        end
    end

    // lock_cnt counts every grant of the current locked burst, including the
    // first one, so MAX_LOCK is the total run length the other master waits out.
    always_comb begin
        last_next     = last;
        lock_cnt_next = lock_cnt;
        if (accept) begin
            last_next = gnt1 ? M1 : M0;
            if (gnt_lock && other_req) begin
                if (last_next != last) begin
                    lock_cnt_next = 8'd1;
                end else if (lock_cnt != LOCK_LIMIT) begin
                    lock_cnt_next = lock_cnt + 8'd1;
                end
            end else begin
                lock_cnt_next = '0;
            end
        end else if (!last_lock) begin
            lock_cnt_next = '0;
        end
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n && !freeze) begin
            if (req0 && req1) begin
                if (lock_hold) begin
                    gnt0 = (last == M0);
                    gnt1 = (last == M1);
                end else begin
                    gnt0 = (last == M1);
                    gnt1 = (last == M0);
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // The RAM registers its own inputs, so the address path stays combinational.
    always_comb begin
        mem_address    = gnt1 ? m1.address    : m0.address;
        mem_byteenable = gnt1 ? m1.byteenable : m0.byteenable;
        mem_writedata  = gnt1 ? m1.writedata  : m0.writedata;
        sel_write      = gnt1 ? m1.write      : m0.write;
        in_range       = ({1'b0, mem_address} < DEPTH_LIMIT);
        mem_chipselect = accept & in_range;
        mem_write      = accept & sel_write & in_range;
    end

    assign m0.waitrequest   = req0 & ~gnt0;
    assign m1.waitrequest   = req1 & ~gnt1;
    assign m0.readdatavalid = rd_pend & (rd_id == 1'b0);
    assign m1.readdatavalid = rd_pend & (rd_id == 1'b1);
    assign m0.readdata      = rd_oor ? '0 : mem_readdata;
    assign m1.readdata      = rd_oor ? '0 : mem_readdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend <= 1'b0;
            rd_id   <= 1'b0;
            rd_oor  <= 1'b0;
        end else begin
            rd_pend <= accept & ~sel_write;
            if (accept) begin
                rd_id  <= gnt1;
                rd_oor <= ~in_range;
            end
        end
    end

    // A new out-of-range access beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            range_err <= 1'b0;
        end else if (accept && !in_range) begin
            range_err <= 1'b1;
        end else if (range_err_clr) begin
            range_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_progmem_arbiter.sv
// Self-checking bench for progmem_arbiter: directed vector table, hand-written
// lock/freeze/reset sequences, then random traffic against a reference model.
module tb_progmem_arbiter;

    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 28912;
    localparam int MAX_LOCK = 8;

    typedef struct {
        logic        rd0, wr0, lk0;
        logic [14:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic        rd1, wr1, lk1;
        logic [14:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic        frz, clr;
    } stim_t;

    typedef struct {
        logic        w0, w1, v0, v1;
        logic [31:0] rdata;
        logic        cs, we, err;
        logic [14:0] addr;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_chipselect;
    logic        mem_write;
    logic        freeze;
    logic        range_err;
    logic        range_err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ram  [0:32767];
    logic [31:0] mmem [0:32767];

    int          m_last;
    int          m_burst;
    bit          m_pend;
    int          m_id;
    logic [31:0] m_data;
    bit          m_err;

    exp_t no_exp;
    vec_t tbl [16];

    always #5 clk = ~clk;

    progmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
    progmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();

    progmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0_bus),
        .m1             (m1_bus),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_readdata   (mem_readdata),
        .freeze         (freeze),
        .range_err      (range_err),
        .range_err_clr  (range_err_clr)
    );

    function automatic logic [31:0] pat(input int a);
        return 32'hCAFE0000 | 32'(a & 'hFFFF);
    endfunction

    // Synchronous single-port RAM: data appears the cycle after the address.
    initial begin
        for (int a = 0; a < 32768; a++) ram[a] <= pat(a);
        forever begin
            @(posedge clk);
            if (mem_chipselect) begin
                if (mem_write) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
                end else begin
                    mem_readdata <= ram[mem_address];
                end
            end
        end
    end

    function automatic stim_t st_idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t acc(input stim_t b, input int m, input bit wr, input int a,
                                  input logic [3:0] be, input logic [31:0] wd);
        stim_t s = b;
        if (m == 0) begin
            s.rd0 = !wr; s.wr0 = wr; s.a0 = 15'(a); s.be0 = be; s.wd0 = wd;
        end else begin
            s.rd1 = !wr; s.wr1 = wr; s.a1 = 15'(a); s.be1 = be; s.wd1 = wd;
        end
        return s;
    endfunction

    function automatic stim_t with_clr(input stim_t b);
        stim_t s = b;
        s.clr = 1'b1;
        return s;
    endfunction

    function automatic exp_t ex(input bit w0, input bit w1, input bit v0, input bit v1,
                                input logic [31:0] rdata, input bit cs, input bit we,
                                input bit err, input int addr);
        exp_t e;
        e.w0 = w0; e.w1 = w1; e.v0 = v0; e.v1 = v1; e.rdata = rdata;
        e.cs = cs; e.we = we; e.err = err; e.addr = 15'(addr);
        return e;
    endfunction

    // Reference model: who wins this cycle, from the arbitration rules.
    function automatic int pick(input stim_t s);
        bit q0 = s.rd0 | s.wr0;
        bit q1 = s.rd1 | s.wr1;
        bit lk = (m_last == 0) ? s.lk0 : s.lk1;
        if (s.frz) return -1;
        if (q0 && q1) begin
            if (lk && m_burst < MAX_LOCK) return m_last;
            return 1 - m_last;
        end
        if (q0) return 0;
        if (q1) return 1;
        return -1;
    endfunction

    function automatic exp_t predict(input stim_t s);
        exp_t e;
        int   g   = pick(s);
        int   ga  = (g == 1) ? int'(s.a1) : int'(s.a0);
        bit   gw  = (g == 1) ? s.wr1 : s.wr0;
        bit   inr = ga < DEPTH;
        e.w0    = (s.rd0 | s.wr0) && g != 0;
        e.w1    = (s.rd1 | s.wr1) && g != 1;
        e.cs    = g >= 0 && inr;
        e.we    = e.cs && gw;
        e.addr  = 15'(ga);
        e.v0    = m_pend && m_id == 0;
        e.v1    = m_pend && m_id == 1;
        e.rdata = m_data;
        e.err   = m_err;
        return e;
    endfunction

    task automatic model_reset();
        m_last = 1; m_burst = 0; m_pend = 0; m_id = 0; m_data = '0; m_err = 0;
    endtask

    task automatic model_update(input stim_t s);
        int          g = pick(s);
        int          ga;
        bit          gw, inr, own_lk, other_q;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          nerr;
        nerr = s.clr ? 1'b0 : m_err;
        m_pend = 0;
        if (g >= 0) begin
            ga      = (g == 1) ? int'(s.a1) : int'(s.a0);
            gw      = (g == 1) ? s.wr1 : s.wr0;
            be      = (g == 1) ? s.be1 : s.be0;
            wd      = (g == 1) ? s.wd1 : s.wd0;
            own_lk  = (g == 1) ? s.lk1 : s.lk0;
            other_q = (g == 1) ? (s.rd0 | s.wr0) : (s.rd1 | s.wr1);
            inr     = ga < DEPTH;
            if (!inr) nerr = 1;
            if (!gw) begin
                m_pend = 1;
                m_id   = g;
                m_data = inr ? mmem[ga] : 32'h0;
            end else if (inr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mmem[ga][b*8 +: 8] = wd[b*8 +: 8];
            end
            if (own_lk && other_q)
                m_burst = (g == m_last) ? ((m_burst < MAX_LOCK) ? m_burst + 1 : MAX_LOCK) : 1;
            else
                m_burst = 0;
            m_last = g;
        end else if (!((m_last == 0) ? s.lk0 : s.lk1)) begin
            m_burst = 0;
        end
        m_err = nerr;
    endtask

    task automatic applyStimulus(input stim_t s);
        m0_bus.read = s.rd0; m0_bus.write = s.wr0; m0_bus.lock = s.lk0;
        m0_bus.address = s.a0; m0_bus.byteenable = s.be0; m0_bus.writedata = s.wd0;
        m1_bus.read = s.rd1; m1_bus.write = s.wr1; m1_bus.lock = s.lk1;
        m1_bus.address = s.a1; m1_bus.byteenable = s.be1; m1_bus.writedata = s.wd1;
        freeze = s.frz;
        range_err_clr = s.clr;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        check({tag, ".wait0"}, 32'(m0_bus.waitrequest), 32'(e.w0));
        check({tag, ".wait1"}, 32'(m1_bus.waitrequest), 32'(e.w1));
        check({tag, ".rdv0"}, 32'(m0_bus.readdatavalid), 32'(e.v0));
        check({tag, ".rdv1"}, 32'(m1_bus.readdatavalid), 32'(e.v1));
        check({tag, ".cs"}, 32'(mem_chipselect), 32'(e.cs));
        check({tag, ".we"}, 32'(mem_write), 32'(e.we));
        check({tag, ".err"}, 32'(range_err), 32'(e.err));
        if (e.v0 || e.v1) begin
            check({tag, ".rdata0"}, m0_bus.readdata, e.rdata);
            check({tag, ".rdata1"}, m1_bus.readdata, e.rdata);
        end
        if (e.cs) check({tag, ".addr"}, 32'(mem_address), 32'(e.addr));
    endtask

    // One clock: drive, check mid-cycle, advance the model at the edge.
    task automatic cycle(input stim_t s, input bit use_tbl, input exp_t te, input string tag);
        exp_t e;
        applyStimulus(s);
        e = predict(s);
        #3;
        checkOutput(tag, use_tbl ? te : e);
        @(posedge clk);
        model_update(s);
        #1;
    endtask

    function automatic stim_t rand_stim();
        stim_t s = st_idle();
        int    r;
        r = $urandom_range(0, 9); s.rd0 = r < 4; s.wr0 = r >= 3 && r < 6;
        r = $urandom_range(0, 9); s.rd1 = r < 4; s.wr1 = r >= 3 && r < 6;
        s.lk0 = $urandom_range(0, 2) == 0;
        s.lk1 = $urandom_range(0, 2) == 0;
        s.a0  = ($urandom_range(0, 15) == 0) ? 15'(DEPTH + $urandom_range(0, 32767 - DEPTH))
                                              : 15'('h100 + $urandom_range(0, 7));
        s.a1  = ($urandom_range(0, 15) == 0) ? 15'(DEPTH + $urandom_range(0, 32767 - DEPTH))
                                              : 15'('h100 + $urandom_range(0, 7));
        s.be0 = 4'($urandom_range(0, 15));
        s.be1 = 4'($urandom_range(0, 15));
        s.wd0 = $urandom;
        s.wd1 = $urandom;
        s.frz = $urandom_range(0, 9) == 0;
        s.clr = $urandom_range(0, 7) == 0;
        return s;
    endfunction

    initial begin
        stim_t s;
        stim_t both;

        for (int a = 0; a < 32768; a++) mmem[a] = pat(a);
        no_exp = ex(0, 0, 0, 0, 0, 0, 0, 0, 0);

        both = acc(acc(st_idle(), 0, 0, 'h10, 0, 0), 1, 0, 'h20, 0, 0);
        tbl[0]  = '{both, ex(0, 1, 0, 0, 0, 1, 0, 0, 'h10)};
        tbl[1]  = '{both, ex(1, 0, 1, 0, pat('h10), 1, 0, 0, 'h20)};
        tbl[2]  = '{both, ex(0, 1, 0, 1, pat('h20), 1, 0, 0, 'h10)};
        tbl[3]  = '{both, ex(1, 0, 1, 0, pat('h10), 1, 0, 0, 'h20)};
        tbl[4]  = '{st_idle(), ex(0, 0, 0, 1, pat('h20), 0, 0, 0, 0)};
        tbl[5]  = '{acc(st_idle(), 0, 1, 'h100, 4'b0011, 32'hDEADBEEF), ex(0, 0, 0, 0, 0, 1, 1, 0, 'h100)};
        tbl[6]  = '{acc(st_idle(), 0, 0, 'h100, 0, 0), ex(0, 0, 0, 0, 0, 1, 0, 0, 'h100)};
        tbl[7]  = '{st_idle(), ex(0, 0, 1, 0, 32'hCAFEBEEF, 0, 0, 0, 0)};
        tbl[8]  = '{acc(st_idle(), 1, 1, DEPTH, 4'hF, 32'h12345678), ex(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{acc(st_idle(), 1, 0, DEPTH, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[10] = '{st_idle(), ex(0, 0, 0, 1, 32'h0, 0, 0, 1, 0)};
        tbl[11] = '{with_clr(st_idle()), ex(0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[12] = '{st_idle(), ex(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[13] = '{with_clr(acc(st_idle(), 1, 1, 'h7FFF, 4'hF, 32'h0BADF00D)), ex(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[14] = '{with_clr(st_idle()), ex(0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[15] = '{st_idle(), ex(0, 0, 0, 0, 0, 0, 0, 0, 0)};

        reset_n = 1'b0;
        applyStimulus(st_idle());
        #2;
        applyStimulus(acc(acc(st_idle(), 0, 0, 'h10, 0, 0), 1, 1, 'h20, 4'hF, 0));
        #1;
        checkOutput("in_reset", ex(1, 1, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(st_idle());
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++)
            cycle(tbl[i].s, 1'b1, tbl[i].e, $sformatf("tbl%0d", i));

        s = acc(acc(st_idle(), 0, 0, 'h30, 0, 0), 1, 0, 'h40, 0, 0);
        s.lk0 = 1'b1;
        for (int i = 0; i < 10; i++)
            cycle(s, 1'b1,
                  ex(i == 8, i != 8, i >= 1 && i != 9, i == 9, (i == 9) ? pat('h40) : pat('h30),
                     1, 0, 0, (i == 8) ? 'h40 : 'h30),
                  $sformatf("lock%0d", i));
        cycle(st_idle(), 1'b0, no_exp, "lock_drain");

        cycle(acc(st_idle(), 0, 0, 'h50, 0, 0), 1'b1, ex(0, 0, 0, 0, 0, 1, 0, 0, 'h50), "frz_acc");
        s = acc(acc(st_idle(), 0, 0, 'h51, 0, 0), 1, 0, 'h52, 0, 0);
        s.frz = 1'b1;
        cycle(s, 1'b1, ex(1, 1, 1, 0, pat('h50), 0, 0, 0, 0), "frz_drain");
        cycle(s, 1'b1, ex(1, 1, 0, 0, 0, 0, 0, 0, 0), "frz_hold0");
        cycle(s, 1'b1, ex(1, 1, 0, 0, 0, 0, 0, 0, 0), "frz_hold1");
        s.frz = 1'b0;
        cycle(s, 1'b0, no_exp, "frz_release");
        cycle(st_idle(), 1'b0, no_exp, "frz_tail");

        cycle(acc(st_idle(), 1, 0, 'h60, 0, 0), 1'b0, no_exp, "rst_rd");
        applyStimulus(acc(st_idle(), 0, 0, 'h61, 0, 0));
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst_mid", ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(st_idle());
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        cycle(st_idle(), 1'b1, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst");
        cycle(acc(acc(st_idle(), 0, 0, 'h70, 0, 0), 1, 0, 'h71, 0, 0), 1'b1,
              ex(0, 1, 0, 0, 0, 1, 0, 0, 'h70), "post_rst_gnt");
        cycle(st_idle(), 1'b0, no_exp, "post_rst_drain");

        for (int i = 0; i < 600; i++)
            cycle(rand_stim(), 1'b0, no_exp, $sformatf("rnd%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
